// File: rtl/shift_seq_pkg.sv
// ----------------------------------------------------------------------------
// shift_seq_pkg
//   Shared definitions for the shift command sequencer and anything that talks
//   to the universal shifter's mode input.
//   - MODE_*  : shifter mode encodings (hold / right / left / load)
//   - state_t : sequencer FSM state encoding (S_IDLE, S_LOAD, S_SHIFT, S_DONE)
//   - dir_mode: maps a shift direction bit onto the matching shifter mode
// ----------------------------------------------------------------------------
package shift_seq_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // dir = 0 shifts right, dir = 1 shifts left.
    function automatic logic [1:0] dir_mode(input logic dir);
        return dir ? MODE_LEFT : MODE_RIGHT;
    endfunction

endpackage

// File: rtl/shift_cmd_buf.sv
// ----------------------------------------------------------------------------
// shift_cmd_buf
//   One-entry command holding register between the command port and the
//   sequencer FSM. A push and a pop in the same cycle leave the entry full
//   with the newly pushed command.
// Ports
//   clk, reset  : rising-edge clock, synchronous active-high reset (flushes)
//   in_valid    : push in_data this cycle; caller only pushes when the entry
//                 is empty or is being popped in the same cycle
//   in_data     : command word to store
//   out_valid   : entry holds a command (also the "full" flag)
//   out_ready   : consumer takes the entry this cycle (ignored when empty)
//   out_data    : stored command word
// ----------------------------------------------------------------------------
module shift_cmd_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (in_valid) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_ready && full_q) begin
            full_q <= 1'b0;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;

endmodule

// File: rtl/shift_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// shift_cmd_sequencer
//   Accepts "optionally load a value, then shift N places left/right" commands
//   and drives the universal shifter's mode/data_in one step per cycle.
//   Finishes each command with a one-cycle done pulse.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high. cmd_* are sampled only on that edge; the source
//   may change them freely at any other time. cmd_ready never depends on
//   cmd_valid.
//
// Ports
//   clk        : rising-edge clock, shared with the shifter
//   reset      : synchronous, active-high; aborts any command in flight
//   cmd_valid  : command present
//   cmd_ready  : sequencer can accept a command
//   cmd_load   : 1 = load cmd_data before shifting
//   cmd_dir    : 0 = shift right, 1 = shift left
//   cmd_data   : value to load
//   cmd_count  : number of shift cycles (0 .. 2**CNT_W-1)
//   sh_mode    : shifter mode (00 hold, 01 right, 10 left, 11 load)
//   sh_data    : shifter data_in; holds the data of the current command
//   busy       : FSM not in IDLE
//   done       : one-cycle pulse in the cycle after the last step
//   dbg_state  : current FSM state (state_t encoding)
//
// Build option: define SHIFT_CMD_QUEUE_EN to add a one-entry command buffer.
//   cmd_ready then means "buffer empty", a command can be queued while busy,
//   and DONE chains straight into the next command without an IDLE cycle.
// ----------------------------------------------------------------------------
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       sh_mode,
    output logic [WIDTH-1:0] sh_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_t           state;
    logic             dir_q;
    logic [CNT_W-1:0] count_q;

    // The command the FSM would start if it were free to start one now.
    logic             nxt_valid;
    logic             nxt_load;
    logic             nxt_dir;
    logic [WIDTH-1:0] nxt_data;
    logic [CNT_W-1:0] nxt_count;

`ifdef SHIFT_CMD_QUEUE_EN
    localparam int CMD_W = 2 + WIDTH + CNT_W;

    logic             take_ok;
    logic             buf_full;
    logic [CMD_W-1:0] buf_data;

    // IDLE and DONE are the only states that can start a new command.
    assign take_ok   = (state == S_IDLE) || (state == S_DONE);
    assign cmd_ready = !buf_full && !reset;

    // With the buffer empty and the FSM free, an accepted command bypasses the
    // buffer so the first step still lands in the cycle after the accept.
    // Otherwise it is parked in the buffer until the current command ends.
    shift_cmd_buf #(
        .W(CMD_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (cmd_valid && cmd_ready && !take_ok),
        .in_data  ({cmd_load, cmd_dir, cmd_data, cmd_count}),
        .out_valid(buf_full),
        .out_ready(take_ok),
        .out_data (buf_data)
    );

    always_comb begin
        nxt_valid = buf_full || (cmd_valid && cmd_ready);
        {nxt_load, nxt_dir, nxt_data, nxt_count} = buf_full ? buf_data
                                               : {cmd_load, cmd_dir, cmd_data, cmd_count};
    end
`else
    assign cmd_ready = (state == S_IDLE) && !reset;

    always_comb begin
        nxt_valid = cmd_valid && cmd_ready;
        nxt_load  = cmd_load;
        nxt_dir   = cmd_dir;
        nxt_data  = cmd_data;
        nxt_count = cmd_count;
    end
`endif

    // FSM with registered outputs: sh_mode/busy/done are written together with
    // the state they belong to, so they always reflect the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            dir_q   <= 1'b0;
            count_q <= '0;
            sh_mode <= MODE_HOLD;
            sh_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // Without the buffer nxt_valid is never set in DONE, so DONE
                // always falls back to IDLE in that build.
                S_IDLE, S_DONE: begin
                    if (nxt_valid) begin
                        dir_q   <= nxt_dir;
                        count_q <= nxt_count;
                        sh_data <= nxt_data;
                        busy    <= 1'b1;
                        if (nxt_load) begin
                            state   <= S_LOAD;
                            sh_mode <= MODE_LOAD;
                        end else if (nxt_count != '0) begin
                            state   <= S_SHIFT;
                            sh_mode <= dir_mode(nxt_dir);
                        end else begin
                            state   <= S_DONE;
                            sh_mode <= MODE_HOLD;
                            done    <= 1'b1;
                        end
                    end else begin
                        state   <= S_IDLE;
                        sh_mode <= MODE_HOLD;
                        busy    <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (count_q != '0) begin
                        state   <= S_SHIFT;
                        sh_mode <= dir_mode(dir_q);
                    end else begin
                        state   <= S_DONE;
                        sh_mode <= MODE_HOLD;
                        done    <= 1'b1;
                    end
                end

                // count_q holds the shifts still to issue, including this one.
                S_SHIFT: begin
                    count_q <= count_q - 1'b1;
                    if (count_q == 1) begin
                        state   <= S_DONE;
                        sh_mode <= MODE_HOLD;
                        done    <= 1'b1;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    sh_mode <= MODE_HOLD;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_shift_cmd_sequencer
//   Directed bench for shift_cmd_sequencer. A small behavioural model of the
//   universal shifter follows sh_mode/sh_data so the net effect of each
//   command on the shifter contents can be checked. Load data seen at each
//   accept is queued and compared against sh_data in every LOAD cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_cmd_sequencer;
    import shift_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef SHIFT_CMD_QUEUE_EN
    localparam int   B2B_PERIOD = 4;
    localparam logic BUSY_READY = 1'b1;
`else
    localparam int   B2B_PERIOD = 5;
    localparam logic BUSY_READY = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_load = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [1:0]       sh_mode;
    logic [WIDTH-1:0] sh_data;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    shift_cmd_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_load (cmd_load),
        .cmd_dir  (cmd_dir),
        .cmd_data (cmd_data),
        .cmd_count(cmd_count),
        .sh_mode  (sh_mode),
        .sh_data  (sh_data),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    // ---------------- shifter model ----------------
    logic [WIDTH-1:0] shreg = '0;
    always @(posedge clk) begin
        case (sh_mode)
            MODE_LOAD:  shreg <= sh_data;
            MODE_RIGHT: shreg <= shreg >> 1;
            MODE_LEFT:  shreg <= shreg << 1;
            default:    shreg <= shreg;
        endcase
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- scoreboard / event monitor ----------------
    logic [WIDTH-1:0] exp_q[$];
    int load_t[$];
    int cyc      = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            if (cmd_load) exp_q.push_back(cmd_data);
        end
        if (done) done_cnt++;
        if (sh_mode == MODE_LOAD) begin
            load_t.push_back(cyc);
            check("sb_load_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("sb_load_data", sh_data, exp_q.pop_front());
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic ld, input logic dir, input logic [WIDTH-1:0] data,
                           input logic [CNT_W-1:0] cnt);
        cmd_load  = ld;
        cmd_dir   = dir;
        cmd_data  = data;
        cmd_count = cnt;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 50) begin
            tick();
            i++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int dbase;
        int abase;
        int lbase;

        // Reset, with a command presented that must be dropped.
        reset = 1'b1;
        set_cmd(1'b1, 1'b0, 4'b1111, 3'd3);
        tick();
        tick();
        check("rst_ready", cmd_ready, 0);
        check("rst_mode", sh_mode, MODE_HOLD);
        check("rst_data", sh_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, S_IDLE);
        cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("idle_ready", cmd_ready, 1);
        tick();
        check("rst_drop", acc_cnt, 0);

        // 1: load 1100, shift right once.
        set_cmd(1'b1, 1'b0, 4'b1100, 3'd1);
        tick();
        cmd_valid = 1'b0;
        check("t1_c1_mode", sh_mode, MODE_LOAD);
        check("t1_c1_data", sh_data, 4'b1100);
        check("t1_c1_busy", busy, 1);
        check("t1_c1_done", done, 0);
        check("t1_c1_ready", cmd_ready, BUSY_READY);
        tick();
        check("t1_c2_mode", sh_mode, MODE_RIGHT);
        check("t1_c2_done", done, 0);
        tick();
        check("t1_c3_mode", sh_mode, MODE_HOLD);
        check("t1_c3_done", done, 1);
        check("t1_c3_state", dbg_state, S_DONE);
        tick();
        check("t1_c4_busy", busy, 0);
        check("t1_c4_done", done, 0);
        check("t1_c4_ready", cmd_ready, 1);
        check("t1_shreg", shreg, 4'b0110);

        // 2: no-op command (no load, count 0).
        set_cmd(1'b0, 1'b1, 4'b0000, 3'd0);
        tick();
        cmd_valid = 1'b0;
        check("t2_c1_done", done, 1);
        check("t2_c1_busy", busy, 1);
        check("t2_c1_mode", sh_mode, MODE_HOLD);
        tick();
        check("t2_c2_busy", busy, 0);
        check("t2_c2_done", done, 0);
        check("t2_c2_mode", sh_mode, MODE_HOLD);
        check("t2_shreg", shreg, 4'b0110);

        // 3: load 1010, shift left 7 times (maximum count).
        set_cmd(1'b1, 1'b1, 4'b1010, 3'd7);
        tick();
        cmd_valid = 1'b0;
        check("t3_load_mode", sh_mode, MODE_LOAD);
        check("t3_load_ready", cmd_ready, BUSY_READY);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t3_shift_mode", sh_mode, MODE_LEFT);
            check("t3_shift_ready", cmd_ready, BUSY_READY);
            check("t3_shift_done", done, 0);
        end
        tick();
        check("t3_done", done, 1);
        check("t3_done_ready", cmd_ready, BUSY_READY);
        tick();
        check("t3_after_done", done, 0);
        check("t3_after_ready", cmd_ready, 1);
        check("t3_shreg", shreg, 4'b0000);

        // 4: two commands held valid back to back (load, count 2 each).
        dbase = done_cnt;
        abase = acc_cnt;
        lbase = load_t.size();
        set_cmd(1'b1, 1'b0, 4'b0001, 3'd2);
        tick();
        cmd_data = 4'b1000;
        for (int i = 0; i < 20 && acc_cnt < abase + 2; i++) tick();
        cmd_valid = 1'b0;
        check("t4_second_accept", acc_cnt, abase + 2);
        wait_idle("t4_idle_timeout");
        check("t4_done_count", done_cnt, dbase + 2);
        check("t4_load_count", load_t.size(), lbase + 2);
        if (load_t.size() >= lbase + 2)
            check("t4_period", load_t[lbase+1] - load_t[lbase], B2B_PERIOD);
        check("t4_shreg", shreg, 4'b0010);

        // 5: reset in the second SHIFT cycle of a count-5 command.
        dbase = done_cnt;
        set_cmd(1'b1, 1'b1, 4'b0011, 3'd5);
        tick();
        cmd_valid = 1'b0;
        check("t5_load_mode", sh_mode, MODE_LOAD);
        tick();
        tick();
        check("t5_shift2_mode", sh_mode, MODE_LEFT);
        reset = 1'b1;
        tick();
        check("t5_abort_mode", sh_mode, MODE_HOLD);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_done", done, 0);
        check("t5_abort_ready", cmd_ready, 0);
        check("t5_abort_state", dbg_state, S_IDLE);
        reset = 1'b0;
        tick();
        tick();
        check("t5_no_done", done_cnt, dbase);
        set_cmd(1'b1, 1'b0, 4'b1001, 3'd0);
        check("t5_new_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t5_new_mode", sh_mode, MODE_LOAD);
        check("t5_new_data", sh_data, 4'b1001);
        tick();
        check("t5_new_done", done, 1);
        check("t5_new_hold", sh_mode, MODE_HOLD);
        tick();
        check("t5_new_idle", busy, 0);
        check("t5_shreg", shreg, 4'b1001);

`ifdef SHIFT_CMD_QUEUE_EN
        // 6: queue a second command while busy, refuse a third until drained.
        set_cmd(1'b1, 1'b0, 4'b0101, 3'd2);
        tick();
        check("t6_ready_while_busy", cmd_ready, 1);
        set_cmd(1'b1, 1'b1, 4'b0011, 3'd1);
        tick();
        set_cmd(1'b0, 1'b0, 4'b0000, 3'd1);
        check("t6_full_ready_a", cmd_ready, 0);
        tick();
        check("t6_full_ready_b", cmd_ready, 0);
        tick();
        check("t6_a_done", done, 1);
        check("t6_full_ready_c", cmd_ready, 0);
        tick();
        check("t6_chain_mode", sh_mode, MODE_LOAD);
        check("t6_chain_state", dbg_state, S_LOAD);
        check("t6_chain_busy", busy, 1);
        check("t6_drained_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t6_b_shift", sh_mode, MODE_LEFT);
        tick();
        check("t6_b_done", done, 1);
        tick();
        check("t6_c_shift", sh_mode, MODE_RIGHT);
        wait_idle("t6_idle_timeout");
        check("t6_shreg", shreg, 4'b0011);
`endif

        check("sb_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
